// File: rtl/paddle_ctrl.sv
// Pong paddle controller: synchronizes and debounces the up/down buttons and steps a
// saturating paddle position while a direction is held. Optional macro: PADDLE_ACCEL_EN.
module paddle_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 500_000,
    parameter int STEP_PX         = 4,
    parameter int SCREEN_H        = 480,
    parameter int PADDLE_H        = 80,
    parameter int Y_INIT          = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       enable,
    input  logic       recenter,
    output logic [9:0] paddle_y,
    output logic       at_top,
    output logic       at_bottom,
    output logic       moving
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW  = $clog2(STEP_CYCLES);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  TMR_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [10:0]    YMAX11   = 11'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]     YMAX10   = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]     YINIT10  = 10'(Y_INIT);
    localparam logic [10:0]    STEP1    = 11'(STEP_PX);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MOVE = 1'b1
    } state_t;

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]     sync_a;
    logic [1:0]     sync_b;
    logic [1:0]     st;
    logic [DBW-1:0] db_cnt [2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            st     <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync_a <= {btn_down, btn_up};
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == st[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    st[i]     <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= DBW'(db_cnt[i] + 1);
                end
            end
        end
    end

    dir_t dir;

    always_comb begin
        case (st)
            2'b01:   dir = DIR_UP;
            2'b10:   dir = DIR_DOWN;
            default: dir = DIR_NONE;
        endcase
    end

    state_t         state, state_n;
    dir_t           last_dir, last_dir_n;
    logic [TW-1:0]  tmr, tmr_n;
    logic           do_step;
    logic           reversal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            last_dir <= DIR_NONE;
            tmr      <= '0;
        end else begin
            state    <= state_n;
            last_dir <= last_dir_n;
            tmr      <= tmr_n;
        end
    end

    always_comb begin
        state_n    = state;
        last_dir_n = last_dir;
        tmr_n      = tmr;
        do_step    = 1'b0;
        reversal   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && dir != DIR_NONE) begin
                    do_step    = 1'b1;
                    tmr_n      = '0;
                    last_dir_n = dir;
                    state_n    = S_MOVE;
                end
            end
            S_MOVE: begin
                if (!enable || dir == DIR_NONE) begin
                    tmr_n   = '0;
                    state_n = S_IDLE;
                end else if (dir != last_dir) begin
                    do_step    = 1'b1;
                    reversal   = 1'b1;
                    tmr_n      = '0;
                    last_dir_n = dir;
                end else if (tmr == TMR_LAST) begin
                    do_step = 1'b1;
                    tmr_n   = '0;
                end else begin
                    tmr_n = TW'(tmr + 1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    logic [10:0] step_w;

`ifdef PADDLE_ACCEL_EN
    localparam logic [10:0] STEP2 = 11'(2 * STEP_PX);
    logic [3:0] acc, acc_n;

    // Counts steps in one direction; the ninth and later steps use double size.
    always_comb begin
        acc_n = acc;
        if (recenter || state_n == S_IDLE) begin
            acc_n = '0;
        end else if (do_step) begin
            if (reversal)          acc_n = 4'd1;
            else if (acc != 4'd8)  acc_n = acc + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else       acc <= acc_n;
    end

    assign step_w = (acc == 4'd8) ? STEP2 : STEP1;
`else
    assign step_w = STEP1;
`endif

    // Step arithmetic is done one bit wider so neither direction can wrap.
    logic [10:0] y_ext, y_up, y_sum, y_down;
    logic [9:0]  paddle_n;

    always_comb begin
        y_ext  = {1'b0, paddle_y};
        y_up   = (y_ext < step_w) ? 11'd0 : (y_ext - step_w);
        y_sum  = y_ext + step_w;
        y_down = (y_sum > YMAX11) ? YMAX11 : y_sum;
        if (recenter)
            paddle_n = YINIT10;
        else if (do_step)
            paddle_n = (dir == DIR_DOWN) ? y_down[9:0] : y_up[9:0];
        else
            paddle_n = paddle_y;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) paddle_y <= YINIT10;
        else       paddle_y <= paddle_n;
    end

    assign at_top    = (paddle_y == 10'd0);
    assign at_bottom = (paddle_y == YMAX10);
    assign moving    = (state == S_MOVE);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: a main instance (Y_INIT=200) and a second instance
// (Y_INIT=6) used for the non-aligned saturation cases at both screen bounds.
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       reset, btn_up, btn_down, enable, recenter;
    logic [9:0] paddle_y;
    logic       at_top, at_bottom, moving;

    logic       b_reset, b_btn_up, b_btn_down, b_enable, b_recenter;
    logic [9:0] b_paddle_y;
    logic       b_at_top, b_at_bottom, b_moving;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    paddle_ctrl #(
        .DEBOUNCE_CYCLES(4), .STEP_CYCLES(3), .STEP_PX(4),
        .SCREEN_H(480), .PADDLE_H(80), .Y_INIT(200)
    ) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .enable(enable), .recenter(recenter), .paddle_y(paddle_y),
        .at_top(at_top), .at_bottom(at_bottom), .moving(moving)
    );

    paddle_ctrl #(
        .DEBOUNCE_CYCLES(4), .STEP_CYCLES(3), .STEP_PX(4),
        .SCREEN_H(480), .PADDLE_H(80), .Y_INIT(6)
    ) dut_b (
        .clk(clk), .reset(b_reset), .btn_up(b_btn_up), .btn_down(b_btn_down),
        .enable(b_enable), .recenter(b_recenter), .paddle_y(b_paddle_y),
        .at_top(b_at_top), .at_bottom(b_at_bottom), .moving(b_moving)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; enable = 1'b1; recenter = 1'b0;
        b_reset = 1'b1; b_btn_up = 1'b0; b_btn_down = 1'b0; b_enable = 1'b1; b_recenter = 1'b0;
        cyc(3);
        check("rst_y", 32'(paddle_y), 200);
        check("rst_top", 32'(at_top), 0);
        check("rst_bot", 32'(at_bottom), 0);
        check("rst_mov", 32'(moving), 0);
        check("rst_b_y", 32'(b_paddle_y), 6);
        reset = 1'b0; b_reset = 1'b0;
        cyc(2);
        check("idle_y", 32'(paddle_y), 200);

        // Held down: first step 7 cycles after press, then every 3.
        btn_down = 1'b1;
        cyc(6);
        check("dn_pre_y", 32'(paddle_y), 200);
        check("dn_pre_mov", 32'(moving), 0);
        cyc(1);
        check("dn_s1_y", 32'(paddle_y), 204);
        check("dn_s1_mov", 32'(moving), 1);
        cyc(2);
        check("dn_gap_y", 32'(paddle_y), 204);
        cyc(1);
        check("dn_s2_y", 32'(paddle_y), 208);
        cyc(3);
        check("dn_s3_y", 32'(paddle_y), 212);
        // Release: steps keep landing until the debounced level clears.
        btn_down = 1'b0;
        cyc(6);
        check("rel_y", 32'(paddle_y), 220);
        check("rel_mov_hi", 32'(moving), 1);
        cyc(1);
        check("rel_mov_lo", 32'(moving), 0);
        check("rel_y_hold", 32'(paddle_y), 220);

        recenter = 1'b1;
        cyc(1);
        recenter = 1'b0;
        check("rc_idle_y", 32'(paddle_y), 200);

        // A 3-cycle glitch is shorter than the debounce window.
        btn_up = 1'b1;
        cyc(3);
        btn_up = 1'b0;
        cyc(2);
        check("gl_mov_mid", 32'(moving), 0);
        cyc(8);
        check("gl_y", 32'(paddle_y), 200);
        check("gl_mov", 32'(moving), 0);

        // Both held is a hold; dropping up yields an immediate down step.
        btn_up = 1'b1; btn_down = 1'b1;
        cyc(10);
        check("both_y", 32'(paddle_y), 200);
        check("both_mov", 32'(moving), 0);
        btn_up = 1'b0;
        cyc(6);
        check("both_rel_pre", 32'(paddle_y), 200);
        cyc(1);
        check("both_rel_y", 32'(paddle_y), 204);
        check("both_rel_mov", 32'(moving), 1);
        btn_down = 1'b0;
        cyc(7);
        check("both_end_y", 32'(paddle_y), 212);
        check("both_end_mov", 32'(moving), 0);
        recenter = 1'b1;
        cyc(1);
        recenter = 1'b0;

        // Recenter coinciding with the scheduled step at y=300.
        btn_down = 1'b1;
        cyc(79);
        check("to300_y", 32'(paddle_y), 300);
        cyc(2);
        recenter = 1'b1;
        cyc(1);
        recenter = 1'b0;
        check("rc_step_y", 32'(paddle_y), 200);
        check("rc_step_mov", 32'(moving), 1);
        cyc(3);
        check("rc_next_y", 32'(paddle_y), 204);

        enable = 1'b0;
        cyc(1);
        check("dis_mov", 32'(moving), 0);
        check("dis_y", 32'(paddle_y), 204);
        cyc(10);
        check("dis_hold_y", 32'(paddle_y), 204);
        enable = 1'b1;
        cyc(1);
        check("en_y", 32'(paddle_y), 208);
        check("en_mov", 32'(moving), 1);

        // Reset mid-motion with the button still held.
        reset = 1'b1;
        #1;
        check("rst_mid_y", 32'(paddle_y), 200);
        check("rst_mid_mov", 32'(moving), 0);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        check("rst_rel_y", 32'(paddle_y), 200);
        cyc(5);
        check("rst_pre_y", 32'(paddle_y), 200);
        check("rst_pre_mov", 32'(moving), 0);
        cyc(1);
        check("rst_s1_y", 32'(paddle_y), 204);
        btn_down = 1'b0;
        cyc(10);
        check("rst_end_y", 32'(paddle_y), 212);
        check("rst_end_mov", 32'(moving), 0);

        // Long hold from 200: ninth and tenth step sizes.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        btn_down = 1'b1;
        cyc(31);
`ifdef PADDLE_ACCEL_EN
        check("acc_s9_y", 32'(paddle_y), 240);
        cyc(3);
        check("acc_s10_y", 32'(paddle_y), 248);
`else
        check("acc_s9_y", 32'(paddle_y), 236);
        cyc(3);
        check("acc_s10_y", 32'(paddle_y), 240);
`endif
        btn_down = 1'b0;
        cyc(12);
        check("acc_end_mov", 32'(moving), 0);

        // Second instance: saturation at the top from y=6.
        b_btn_up = 1'b1;
        cyc(7);
        check("b_up_s1", 32'(b_paddle_y), 2);
        check("b_up_top0", 32'(b_at_top), 0);
        cyc(3);
        check("b_up_s2", 32'(b_paddle_y), 0);
        check("b_up_top1", 32'(b_at_top), 1);
        cyc(3);
        check("b_up_hold", 32'(b_paddle_y), 0);
        check("b_up_mov", 32'(b_moving), 1);
        b_btn_up = 1'b0;
        cyc(10);
        check("b_up_end_mov", 32'(b_moving), 0);
        check("b_up_end_y", 32'(b_paddle_y), 0);

        // Second instance: saturation at the bottom, 398 -> 400.
        b_reset = 1'b1;
        #1;
        check("b_rst_y", 32'(b_paddle_y), 6);
        cyc(1);
        b_reset = 1'b0;
        b_btn_down = 1'b1;
        cyc(7);
        check("b_dn_s1", 32'(b_paddle_y), 10);
        cyc(291);
        check("b_dn_398", 32'(b_paddle_y), 398);
        check("b_dn_bot0", 32'(b_at_bottom), 0);
        cyc(3);
        check("b_dn_400", 32'(b_paddle_y), 400);
        check("b_dn_bot1", 32'(b_at_bottom), 1);
        cyc(3);
        check("b_dn_hold", 32'(b_paddle_y), 400);
        check("b_dn_mov", 32'(b_moving), 1);
        b_btn_down = 1'b0;
        cyc(10);
        check("b_dn_end_mov", 32'(b_moving), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
